// File: rtl/m_ifetch_buf.sv
// m_ifetch_buf -- instruction fetch stage with a small prefetch queue.
//
// Owns the PC and issues sequential word fetches to a 1-cycle-latency
// instruction memory. Returned {pc, inst} pairs are queued in a FIFO and
// presented to decode through a valid/ready handshake. A redirect flushes
// the queue, discards the response in flight, and restarts fetch at a new PC.
//
// Optional build macro: IFB_BYPASS_EN
//   When defined, a live response that arrives while the FIFO is empty is
//   presented to decode combinationally in the same cycle. If decode takes it,
//   it is not written into the FIFO.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 2)
//   RESET_PC PC loaded on reset
//
// Ports:
//   w_clk, w_rst               clock, synchronous active-high reset
//   w_imem_req, w_imem_adr     fetch request / word address
//   w_imem_inst                instruction, valid the cycle after a request
//   w_redirect, w_redirect_pc  flush and restart fetch at a new PC
//   w_out_valid, w_out_ready   handshake toward decode
//   w_out_pc, w_out_inst       head entry
//   w_count                    occupied FIFO entries
module m_ifetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  output logic                     w_imem_req,
  output logic [31:0]              w_imem_adr,
  input  logic [31:0]              w_imem_inst,
  input  logic                     w_redirect,
  input  logic [31:0]              w_redirect_pc,
  output logic                     w_out_valid,
  input  logic                     w_out_ready,
  output logic [31:0]              w_out_pc,
  output logic [31:0]              w_out_inst,
  output logic [$clog2(DEPTH):0]   w_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];

  logic w_fifo_nz;
  logic w_live;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_fifo_nz = (r_count != '0);
    // A response is live only if no redirect is killing it this cycle.
    w_live    = r_inflight && !w_redirect;
`ifdef IFB_BYPASS_EN
    w_bypass  = w_live && !w_fifo_nz;
`else
    w_bypass  = 1'b0;
`endif
    // The in-flight slot is reserved up front so a push can never overflow;
    // a same-cycle pop is deliberately not credited.
    w_imem_req  = !w_rst && !w_redirect &&
                  ((r_count + CW'(r_inflight)) < CW'(DEPTH));
    w_imem_adr  = r_pc;
    w_out_valid = w_fifo_nz || w_bypass;
    w_out_pc    = '0;
    w_out_inst  = '0;
    if (w_fifo_nz) begin
      w_out_pc   = r_mem_pc[r_rd_ptr];
      w_out_inst = r_mem_inst[r_rd_ptr];
    end else if (w_bypass) begin
      w_out_pc   = r_req_pc;
      w_out_inst = w_imem_inst;
    end
    // Redirect beats pop: the handshake in the redirect cycle is dropped.
    w_pop   = w_fifo_nz && w_out_ready && !w_redirect;
    w_push  = w_live && !(w_bypass && w_out_ready);
    w_count = r_count;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_pc       <= {w_redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_imem_req) begin
        r_req_pc   <= r_pc;
        r_pc       <= r_pc + 32'd4;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible behind a valid count.
  always_ff @(posedge w_clk) begin
    if (!w_rst && !w_redirect && w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_req_pc;
      r_mem_inst[r_wr_ptr] <= w_imem_inst;
    end
  end

endmodule

// File: tb/tb_m_ifetch_buf.sv
// tb_m_ifetch_buf -- self-checking bench for m_ifetch_buf.
// Directed scenarios check fixed sequences; a randomized run compares every
// cycle against a queue-based reference model of the fetch buffer.
// Build with IFB_BYPASS_EN defined to exercise the bypass variant.
module tb_m_ifetch_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int L   = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int L   = 2;
`endif

  logic          w_clk;
  logic          w_rst;
  logic          w_imem_req;
  logic [31:0]   w_imem_adr;
  logic [31:0]   w_imem_inst;
  logic          w_redirect;
  logic [31:0]   w_redirect_pc;
  logic          w_out_valid;
  logic          w_out_ready;
  logic [31:0]   w_out_pc;
  logic [31:0]   w_out_inst;
  logic [CW-1:0] w_count;

  int checks   = 0;
  int failures = 0;

  m_ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_imem_req(w_imem_req), .w_imem_adr(w_imem_adr), .w_imem_inst(w_imem_inst),
    .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
    .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
    .w_out_pc(w_out_pc), .w_out_inst(w_out_inst), .w_count(w_count)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  // Instruction memory: word at address A holds A>>2, one cycle latency.
  always @(posedge w_clk)
    w_imem_inst <= w_imem_req ? (w_imem_adr >> 2) : 32'hDEAD_BEEF;

  // Reference model: PC, one outstanding fetch, queue of {pc, inst}.
  logic [31:0] m_pc = 32'h0;
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [63:0] m_q[$];

  logic          obs_req, obs_valid;
  logic [31:0]   obs_adr, obs_pc, obs_inst;
  logic [CW-1:0] obs_count;
  logic          exp_req, exp_valid;
  logic [31:0]   exp_adr, exp_pc, exp_inst;
  logic [CW-1:0] exp_count;

  // One clock cycle: apply inputs, sample outputs mid-cycle, predict, advance.
  task automatic drive(input logic r, input logic d, input logic [31:0] p,
                       input logic y);
    int unsigned qn;
    bit          byp;
    w_rst = r; w_redirect = d; w_redirect_pc = p; w_out_ready = y;
    #4;
    obs_req = w_imem_req;   obs_adr = w_imem_adr;  obs_valid = w_out_valid;
    obs_pc  = w_out_pc;     obs_inst = w_out_inst; obs_count = w_count;
    qn        = m_q.size();
    exp_req   = !r && !d && (qn + int'(m_infl) < DEPTH);
    exp_adr   = m_pc;
    byp       = BYP && m_infl && !d && (qn == 0);
    exp_valid = (qn != 0) || byp;
    exp_pc    = (qn != 0) ? m_q[0][63:32] : m_infl_pc;
    exp_inst  = (qn != 0) ? m_q[0][31:0]  : (m_infl_pc >> 2);
    exp_count = CW'(qn);
    @(posedge w_clk);
    if (r) begin
      m_pc = 32'h0; m_infl = 1'b0; m_q.delete();
    end else if (d) begin
      m_pc = {p[31:2], 2'b00}; m_infl = 1'b0; m_q.delete();
    end else begin
      if (qn != 0 && y) void'(m_q.pop_front());
      if (m_infl && !(byp && y)) m_q.push_back({m_infl_pc, m_infl_pc >> 2});
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic y);
    drive(1'b1, 1'b0, 32'h0, y);
    drive(1'b1, 1'b0, 32'h0, y);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs_req !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b exp=0", obs_req);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({obs_req, obs_valid, obs_count} !== {1'b0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL reset_state got req=%b valid=%b count=%0d exp 0/0/0",
               obs_req, obs_valid, obs_count);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({obs_req, obs_adr, obs_valid, obs_count} !== {1'b1, 32'h0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL reset_release got req=%b adr=%h valid=%b count=%0d exp 1/0/0/0",
               obs_req, obs_adr, obs_valid, obs_count);
    end
  endtask

  task automatic test_latency;
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({obs_req, obs_adr, obs_valid} !== {1'b1, 32'(4 * c), (c >= L)}) begin
        failures++;
        $display("FAIL latency_c%0d got req=%b adr=%h valid=%b exp adr=%h valid=%b",
                 c, obs_req, obs_adr, obs_valid, 32'(4 * c), (c >= L));
      end
      if (c >= L) begin
        checks++;
        if ({obs_pc, obs_inst} !== {32'(4 * (c - L)), 32'(c - L)}) begin
          failures++;
          $display("FAIL latency_out_c%0d got pc=%h inst=%h exp pc=%h inst=%h",
                   c, obs_pc, obs_inst, 32'(4 * (c - L)), 32'(c - L));
        end
      end
      if (BYP) begin
        checks++;
        if (obs_count !== CW'(0)) begin
          failures++; $display("FAIL bypass_count_c%0d got=%0d exp=0", c, obs_count);
        end
      end
    end
  endtask

  task automatic test_full;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (obs_req !== (c < 4)) begin
        failures++; $display("FAIL full_req_c%0d got=%b exp=%b", c, obs_req, (c < 4));
      end
    end
    checks++;
    if ({obs_count, obs_valid, obs_pc} !== {CW'(DEPTH), 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL full_hold got count=%0d valid=%b pc=%h exp 4/1/0",
               obs_count, obs_valid, obs_pc);
    end
    for (int c = 10; c < 15; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({obs_valid, obs_pc} !== {1'b1, 32'(4 * (c - 10))}) begin
        failures++;
        $display("FAIL drain_c%0d got valid=%b pc=%h exp valid=1 pc=%h",
                 c, obs_valid, obs_pc, 32'(4 * (c - 10)));
      end
      if (c == 10 || c == 11) begin
        checks++;
        if ({obs_req, obs_adr} !== {(c == 11), (c == 11) ? 32'h10 : obs_adr}) begin
          failures++;
          $display("FAIL drain_req_c%0d got req=%b adr=%h exp req=%b",
                   c, obs_req, obs_adr, (c == 11));
        end
      end
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h103, 1'b1);
    checks++;
    if ({obs_count, obs_req} !== {CW'(3), 1'b0}) begin
      failures++;
      $display("FAIL redirect_cycle got count=%0d req=%b exp 3/0", obs_count, obs_req);
    end
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 1) begin
        checks++;
        if ({obs_req, obs_adr, obs_count} !== {1'b1, 32'h100, CW'(0)}) begin
          failures++;
          $display("FAIL redirect_refetch got req=%b adr=%h count=%0d exp 1/100/0",
                   obs_req, obs_adr, obs_count);
        end
      end
      checks++;
      if (obs_valid !== (k >= 1 + L)) begin
        failures++;
        $display("FAIL redirect_valid_k%0d got=%b exp=%b", k, obs_valid, (k >= 1 + L));
      end else if (obs_valid && obs_pc !== 32'h100 + 32'(4 * (k - 1 - L))) begin
        failures++;
        $display("FAIL redirect_pc_k%0d got=%h exp=%h",
                 k, obs_pc, 32'h100 + 32'(4 * (k - 1 - L)));
      end
    end
  endtask

  task automatic test_reset_inflight;
    do_reset(1'b0);
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({obs_req, obs_adr} !== {1'b1, 32'h40}) begin
      failures++; $display("FAIL rstmid_fetch got req=%b adr=%h exp 1/40", obs_req, obs_adr);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        checks++;
        if ({obs_valid, obs_count, obs_req, obs_adr} !== {1'b0, CW'(0), 1'b1, 32'h0}) begin
          failures++;
          $display("FAIL rstmid_after got valid=%b count=%0d req=%b adr=%h exp 0/0/1/0",
                   obs_valid, obs_count, obs_req, obs_adr);
        end
      end
      checks++;
      if (obs_valid !== (k >= L) || (obs_valid && obs_pc !== 32'(4 * (k - L)))) begin
        failures++;
        $display("FAIL rstmid_out_k%0d got valid=%b pc=%h exp valid=%b pc=%h",
                 k, obs_valid, obs_pc, (k >= L), 32'(4 * (k - L)));
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    do_reset(1'b1);
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      e = 32'hFFFF_FFF8 + 32'(4 * (k - L));
      checks++;
      if (obs_valid !== (k >= L) ||
          (obs_valid && {obs_pc, obs_inst} !== {e, e >> 2})) begin
        failures++;
        $display("FAIL wrap_k%0d got valid=%b pc=%h inst=%h exp valid=%b pc=%h",
                 k, obs_valid, obs_pc, obs_inst, (k >= L), e);
      end
    end
  endtask

  task automatic test_random;
    logic r, d, y;
    do_reset(1'b1);
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 99) == 0);
      d = ($urandom_range(0, 11) == 0);
      y = ($urandom_range(0, 9) < 7);
      drive(r, d, $urandom, y);
      checks++;
      if (obs_req !== exp_req || (exp_req && obs_adr !== exp_adr) ||
          obs_valid !== exp_valid || obs_count !== exp_count ||
          (exp_valid && {obs_pc, obs_inst} !== {exp_pc, exp_inst})) begin
        failures++;
        $display("FAIL random_c%0d got req=%b adr=%h valid=%b pc=%h inst=%h count=%0d exp req=%b adr=%h valid=%b pc=%h inst=%h count=%0d",
                 c, obs_req, obs_adr, obs_valid, obs_pc, obs_inst, obs_count,
                 exp_req, exp_adr, exp_valid, exp_pc, exp_inst, exp_count);
      end
    end
  endtask

  initial begin
    w_rst = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_out_ready = 1'b0;
    @(posedge w_clk);
    #1;
    test_reset();
    test_latency();
    test_full();
    test_redirect();
    test_reset_inflight();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
